// File: rtl/apb_master_bridge.sv
// APB3 initiator bridge: turns single core req/gnt/rvalid transfers into APB SETUP/ACCESS
// cycles, with an address-window filter and a PREADY timeout so a hung slave never stalls the core.
module apb_master_bridge #(
    parameter int unsigned                  ADDR_WIDTH     = 32,
    parameter int unsigned                  DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]        APB_BASE       = ADDR_WIDTH'(32'h1A10_0000),
    parameter logic [ADDR_WIDTH-1:0]        APB_SIZE       = ADDR_WIDTH'(32'h0010_0000),
    parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic                  pwrite_o,
    output logic                  psel_o,
    output logic                  penable_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic                  we_q,      we_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  err_q,     err_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  psel_q,    psel_d;
    logic                  penable_q, penable_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic                  gnt_c;
    logic                  in_window_c;
    logic [ADDR_WIDTH-1:0] offset_c;
    logic                  timeout_hit_c;

    // Unsigned offset compare also rejects addresses below the base (they wrap to large values).
    assign offset_c      = data_addr_i - APB_BASE;
    assign in_window_c   = (offset_c < APB_SIZE);
    assign timeout_hit_c = TIMEOUT_EN && (cnt_q == CNT_LAST);

    // State and captured-request registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            rvalid_q  <= rvalid_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next-output logic; APB strobes are computed for the state being entered
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rvalid_d  = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = cnt_q;
        gnt_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_c = data_req_i;
                if (data_req_i) begin
                    addr_d  = data_addr_i;
                    we_d    = data_we_i;
                    wdata_d = data_wdata_i;
                    if (in_window_c) begin
                        state_d = SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
                cnt_d     = '0;
            end

            ACCESS: begin
                if (pready_i) begin
                    // Completion takes priority over a timeout reached in the same cycle
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = (!we_q && !pslverr_i) ? prdata_i : '0;
                    err_d    = pslverr_i;
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (timeout_hit_c) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b1;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_gnt_o    = gnt_c;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pwrite_o  = we_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table driven through a bus-level driver and
// an APB slave responder, with a response scoreboard and hand-written reset/back-to-back cases.
module tb_apb_master_bridge;

    logic        clk_i;
    logic        rst_ni;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;

    apb_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .APB_BASE       (32'h1A10_0000),
        .APB_SIZE       (32'h0010_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .data_req_i    (data_req_i),
        .data_addr_i   (data_addr_i),
        .data_we_i     (data_we_i),
        .data_wdata_i  (data_wdata_i),
        .data_gnt_o    (data_gnt_o),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_err_o    (data_err_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pwrite_o      (pwrite_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .prdata_i      (prdata_i),
        .pready_i      (pready_i),
        .pslverr_i     (pslverr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          waits;     // ACCESS cycles with pready low before pready high
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;   // cycles from gnt to rvalid
        int          exp_pen;   // cycles with penable high
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pen;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Acts as APB slave and waits for the response; hold_req keeps req high for a follow-on request.
    task automatic wait_resp(input vec_t v, input logic hold_req);
        int   cyc;
        int   pen;
        int   psel_n;
        logic done;
        exp_t e;
        cyc = 0; pen = 0; psel_n = 0; done = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
            if (!hold_req) data_req_i = 1'b0;
            else check("gnt_low_busy", 32'(data_gnt_o), 32'd0);
            pready_i  = 1'b0;
            pslverr_i = 1'b0;
            if (psel_o) begin
                psel_n++;
                check("paddr", paddr_o, v.addr);
                check("pwrite", 32'(pwrite_o), 32'(v.we));
                if (v.we) check("pwdata", pwdata_o, v.wdata);
                if (penable_o) begin
                    pen++;
                    if (pen == v.waits + 1) begin
                        pready_i  = 1'b1;
                        prdata_i  = v.prdata;
                        pslverr_i = v.slverr;
                    end
                end
            end
            if (data_rvalid_o) begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", data_rdata_o, e.rdata);
                    check("err", 32'(data_err_o), 32'(e.err));
                    check("latency", 32'(cyc), 32'(e.lat));
                    check("penable_cycles", 32'(pen), 32'(e.pen));
                    check("psel_cycles", 32'(psel_n), (e.pen == 0) ? 32'd0 : 32'(e.pen + 1));
                end
            end
        end
        if (!done) check("rvalid_timeout", 32'd0, 32'd1);
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
    endtask

    task automatic run_xfer(input vec_t v, input logic hold_req);
        exp_t e;
        @(negedge clk_i);
        data_req_i   = 1'b1;
        data_addr_i  = v.addr;
        data_we_i    = v.we;
        data_wdata_i = v.wdata;
        #1;
        check("gnt", 32'(data_gnt_o), 32'd1);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = v.exp_lat;
        e.pen   = v.exp_pen;
        exp_q.push_back(e);
        wait_resp(v, hold_req);
    endtask

    vec_t vecs[12];
    vec_t bb_a;
    vec_t bb_b;
    vec_t post_rst;

    initial begin
        // addr, we, wdata, waits, prdata, slverr, exp_rdata, exp_err, exp_lat, exp_pen
        vecs[0]  = '{32'h1A10_2000, 1'b0, 32'h0,         0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 1};
        vecs[1]  = '{32'h1A10_0008, 1'b1, 32'h0000_00A5, 3, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 6, 4};
        vecs[2]  = '{32'h1A20_0000, 1'b0, 32'h0,         0, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 1, 0};
        vecs[3]  = '{32'h1A10_0100, 1'b0, 32'h0,         9, 32'h2222_2222, 1'b0, 32'h0,         1'b1, 6, 4};
        vecs[4]  = '{32'h1A10_0104, 1'b0, 32'h0,         3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 6, 4};
        vecs[5]  = '{32'h1A10_0010, 1'b0, 32'h0,         0, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 3, 1};
        vecs[6]  = '{32'h1A10_0020, 1'b1, 32'h5A5A_0F0F, 1, 32'h3333_3333, 1'b1, 32'h0,         1'b1, 4, 2};
        vecs[7]  = '{32'h1A0F_FFFC, 1'b0, 32'h0,         0, 32'h4444_4444, 1'b0, 32'h0,         1'b1, 1, 0};
        vecs[8]  = '{32'h1A1F_FFFC, 1'b0, 32'h0,         0, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 3, 1};
        vecs[9]  = '{32'h1A10_0000, 1'b0, 32'h0,         2, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 1'b0, 5, 3};
        vecs[10] = '{32'h1A20_0000, 1'b1, 32'h7777_7777, 0, 32'h0,         1'b0, 32'h0,         1'b1, 1, 0};
        vecs[11] = '{32'h0000_0000, 1'b0, 32'h0,         0, 32'h6666_6666, 1'b0, 32'h0,         1'b1, 1, 0};
        bb_a     = '{32'h1A10_0040, 1'b0, 32'h0,         0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0, 3, 1};
        bb_b     = '{32'h1A10_0044, 1'b1, 32'hA5A5_5A5A, 0, 32'h0,         1'b0, 32'h0,         1'b0, 3, 1};
        post_rst = '{32'h1A10_0300, 1'b0, 32'h0,         1, 32'h8765_4321, 1'b0, 32'h8765_4321, 1'b0, 4, 2};

        rst_ni       = 1'b0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_we_i    = 1'b0;
        data_wdata_i = '0;
        prdata_i     = '0;
        pready_i     = 1'b0;
        pslverr_i    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_gnt", 32'(data_gnt_o), 32'd0);
        check("rst_rvalid", 32'(data_rvalid_o), 32'd0);
        check("rst_rdata", data_rdata_o, 32'd0);
        check("rst_err", 32'(data_err_o), 32'd0);
        check("rst_paddr", paddr_o, 32'd0);
        check("rst_pwdata", pwdata_o, 32'd0);
        check("rst_pwrite", 32'(pwrite_o), 32'd0);
        check("rst_psel", 32'(psel_o), 32'd0);
        check("rst_penable", 32'(penable_o), 32'd0);
        rst_ni = 1'b1;

        foreach (vecs[i]) run_xfer(vecs[i], 1'b0);

        // Back-to-back with req held: second gnt one cycle after first rvalid
        run_xfer(bb_a, 1'b1);
        run_xfer(bb_b, 1'b0);

        // Reset asserted during ACCESS: strobes drop immediately and no response appears
        @(negedge clk_i);
        data_req_i  = 1'b1;
        data_addr_i = 32'h1A10_0200;
        data_we_i   = 1'b0;
        begin
            int guard;
            guard = 0;
            @(negedge clk_i);
            data_req_i = 1'b0;
            while (!penable_o && guard < 10) begin
                @(negedge clk_i);
                guard++;
            end
            check("rst_seq_reached_access", 32'(penable_o), 32'd1);
        end
        rst_ni = 1'b0;
        #1;
        check("midrst_psel", 32'(psel_o), 32'd0);
        check("midrst_penable", 32'(penable_o), 32'd0);
        repeat (3) begin
            @(negedge clk_i);
            check("midrst_no_rvalid", 32'(data_rvalid_o), 32'd0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("postrst_no_rvalid", 32'(data_rvalid_o), 32'd0);
        run_xfer(post_rst, 1'b0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
